// File: rtl/mult4u_residue_checker.sv
// Sequential wrapper around a combinational 4x4 unsigned multiplier. The product is checked with
// mod-3 (and optionally mod-5) residue codes, re-evaluated on mismatch, and persistent faults are counted.
module mult4u_residue_checker #(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8,
  parameter bit USE_MOD5  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_p,
  output logic             out_err,
  output logic [2:0]       out_retries,
  output logic [CNT_W-1:0] fault_cnt
);

  if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_max_retry
    $error("MAX_RETRY must be in 0..7");
  end

  typedef enum logic [1:0] {IDLE, EVAL, CHECK, DONE} state_t;

  localparam logic [2:0]       MAX_RETRY_L = 3'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t     state, state_next;
  logic [7:0] p_reg;
  logic [2:0] retries;
  logic       mod3_ok, mod5_ok, check_pass, retry_left;

  // 4^k == 1 (mod 3): fold base-4 digits, then trim the small remainder.
  function automatic logic [1:0] mod3(input logic [7:0] v);
    logic [3:0] s;
    logic [2:0] t;
    s = {2'b00, v[1:0]} + {2'b00, v[3:2]} + {2'b00, v[5:4]} + {2'b00, v[7:6]};
    t = {1'b0, s[1:0]} + {1'b0, s[3:2]};
    if (t >= 3'd3) t = t - 3'd3;
    if (t >= 3'd3) t = t - 3'd3;
    return t[1:0];
  endfunction

  // 16 == 1 (mod 5): fold nibbles twice, then trim.
  function automatic logic [2:0] mod5(input logic [7:0] v);
    logic [4:0] s;
    logic [3:0] t;
    s = {1'b0, v[3:0]} + {1'b0, v[7:4]};
    t = s[3:0] + {3'b000, s[4]};
    if (t >= 4'd10) t = t - 4'd10;
    if (t >= 4'd5)  t = t - 4'd5;
    return t[2:0];
  endfunction

  logic [1:0] ra3, rb3;
  assign ra3     = mod3({4'h0, mul_a});
  assign rb3     = mod3({4'h0, mul_b});
  assign mod3_ok = (mod3(p_reg) == mod3({6'b0, ra3} * {6'b0, rb3}));

  if (USE_MOD5) begin : g_mod5
    logic [2:0] ra5, rb5;
    assign ra5     = mod5({4'h0, mul_a});
    assign rb5     = mod5({4'h0, mul_b});
    assign mod5_ok = (mod5(p_reg) == mod5({5'b0, ra5} * {5'b0, rb5}));
  end else begin : g_no_mod5
    assign mod5_ok = 1'b1;
  end

  assign check_pass = mod3_ok && mod5_ok;
  assign retry_left = (retries < MAX_RETRY_L);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = EVAL;
      EVAL:    state_next = CHECK;
      CHECK:   state_next = (!check_pass && retry_left) ? EVAL : DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a       <= '0;
      mul_b       <= '0;
      p_reg       <= '0;
      retries     <= '0;
      out_p       <= '0;
      out_err     <= 1'b0;
      out_retries <= '0;
      fault_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mul_a   <= in_a;
          mul_b   <= in_b;
          retries <= '0;
        end
        EVAL: p_reg <= mul_p;
        CHECK: begin
          if (check_pass) begin
            out_p       <= p_reg;
            out_err     <= 1'b0;
            out_retries <= retries;
          end else if (retry_left) begin
            retries <= retries + 3'd1;
          end else begin
            out_p       <= p_reg;
            out_err     <= 1'b1;
            out_retries <= retries;
            if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
